dep_share_arbiter: RTL

Round-robin arbiter and sequencer that shares one external 3-input evaluation unit (dependence_1-style a/b/c -> Result) between NUM_REQ requesters. It owns a single transaction slot: it grants one requester, drives the unit operands, waits the unit's fixed latency and returns the tagged result. This removes the current practice of instantiating one evaluation unit per consumer with outputs wired together.

---
 rtl/dep_share_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dep_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dep_share_arbiter
// Brief   : Round-robin sequencer sharing one fixed-latency a/b/c evaluation
//           unit between NUM_REQ requesters, one transaction in flight.
// Revision: 1.0 - initial release
// ============================================================================
module dep_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int UNIT_LAT = 2,
  parameter int ID_W     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0] req_c,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               unit_a,
  output logic               unit_b,
  output logic               unit_c,
  output logic               unit_start,
  input  logic               unit_result,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_result,
  input  logic               rsp_ready,
  output logic               busy,
  output logic               drop_err
);

  localparam int               CNT_W     = $clog2(UNIT_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(UNIT_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
  localparam logic [ID_W-1:0]  PTR_RESET = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]    NR_WIDE   = (ID_W + 1)'(NUM_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         state_q,      state_d;
  logic [ID_W-1:0]    rr_ptr_q,     rr_ptr_d;
  logic [ID_W-1:0]    gnt_id_q,     gnt_id_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [NUM_REQ-1:0] req_ready_q,  req_ready_d;
  logic               unit_a_q,     unit_a_d;
  logic               unit_b_q,     unit_b_d;
  logic               unit_c_q,     unit_c_d;
  logic               unit_start_q, unit_start_d;
  logic               rsp_valid_q,  rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q,     rsp_id_d;
  logic               rsp_result_q, rsp_result_d;
  logic               drop_err_q,   drop_err_d;

  logic [ID_W:0]      cand;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic [NUM_REQ-1:0] win_onehot;

  // Search starts just after the last served requester; the wrap is a single
  // subtraction because rr_ptr + k never reaches 2*NUM_REQ.
  always_comb begin
    cand      = '0;
    win_id    = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
      if (cand >= NR_WIDE) begin
        cand = cand - NR_WIDE;
      end
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
    win_onehot         = '0;
    win_onehot[win_id] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_id_d     = gnt_id_q;
    cnt_d        = cnt_q;
    req_ready_d  = '0;
    unit_a_d     = unit_a_q;
    unit_b_d     = unit_b_q;
    unit_c_d     = unit_c_q;
    unit_start_d = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    drop_err_d   = drop_err_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_id_d    = win_id;
          req_ready_d = win_onehot;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        if (req_valid[gnt_id_q]) begin
          unit_a_d     = req_a[gnt_id_q];
          unit_b_d     = req_b[gnt_id_q];
          unit_c_d     = req_c[gnt_id_q];
          unit_start_d = 1'b1;
          cnt_d        = CNT_LOAD;
          rr_ptr_d     = gnt_id_q;
          state_d      = S_WAIT;
        end else begin
          // Requester withdrew before its grant: flag it, keep its priority.
          drop_err_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rsp_result_d = unit_result;
          rsp_id_d     = gnt_id_q;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= PTR_RESET;
      gnt_id_q     <= '0;
      cnt_q        <= '0;
      req_ready_q  <= '0;
      unit_a_q     <= 1'b0;
      unit_b_q     <= 1'b0;
      unit_c_q     <= 1'b0;
      unit_start_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_id_q     <= gnt_id_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      unit_a_q     <= unit_a_d;
      unit_b_q     <= unit_b_d;
      unit_c_q     <= unit_c_d;
      unit_start_q <= unit_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign unit_a     = unit_a_q;
  assign unit_b     = unit_b_q;
  assign unit_c     = unit_c_q;
  assign unit_start = unit_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != S_IDLE);
  assign drop_err   = drop_err_q;

endmodule
`default_nettype wire
